// File: rtl/pix_pkg.sv
// rtl/pix_pkg.sv - shared types and constants for the pixel writer
// Contents:
//   state_t       writer FSM state encoding (IDLE, WRITE)
//   KBUS_W        pixel command width
//   X/Y/COL_*     bit positions of the X, Y and colour fields on kbus
//   DEF_SCREEN_*  default screen geometry
package pix_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int KBUS_W = 24;

  localparam int X_MSB   = 23;
  localparam int X_LSB   = 16;
  localparam int Y_MSB   = 15;
  localparam int Y_LSB   = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous pixel command FIFO with first-word fall-through read
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (empties the FIFO)
//   push   in   store din this edge (ignored while full)
//   pop    in   drop head entry this edge (ignored while empty)
//   din    in   WIDTH  entry to store
//   dout   out  WIDTH  current head entry, valid while !empty
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module pix_fifo
  import pix_pkg::*;
#(
  parameter int WIDTH = KBUS_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  // One bit wider than the pointers so full and empty are distinct.
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers kbus pixel commands and issues framebuffer writes
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   kbus        in   24      pixel command {X[7:0], Y[7:0], colour[7:0]}
//   kbus_valid  in   command present on kbus
//   kbus_ready  out  command FIFO not full
//   fb_addr     out  ADDR_W  linear write address Y*SCREEN_W+X
//   fb_data     out  8       colour to write
//   fb_we       out  write request, held until fb_ack
//   fb_ack      in   framebuffer accepted the write this cycle
//   busy        out  FIFO non-empty or write outstanding
//   pix_cnt     out  16      completed writes, wrapping
//   drop_cnt    out  16      clipped commands
// Build option PIX_CLIP_EN: discard commands outside the screen and count
// them in drop_cnt; without it every command is written and drop_cnt is 0.
module pixel_writer
  import pix_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KBUS_W-1:0] kbus,
  input  logic              kbus_valid,
  output logic              kbus_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ack,
  output logic              busy,
  output logic [15:0]       pix_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int AFW = ADDR_W + 8;

  state_t            state;
  state_t            state_d;
  logic [KBUS_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              load;
  logic              we_d;
  logic              pix_inc;
  logic              drop_inc;
  logic              clip;
  logic [7:0]        head_x;
  logic [7:0]        head_y;
  logic [7:0]        head_col;
  logic [AFW-1:0]    lin_addr;
  logic [7:0]        unused_lin_hi;

  assign kbus_ready = !full;
  assign push       = kbus_valid && !full;
  assign busy       = !empty || fb_we;

  pix_fifo #(
    .WIDTH (KBUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (kbus),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_x   = head[X_MSB:X_LSB];
  assign head_y   = head[Y_MSB:Y_LSB];
  assign head_col = head[COL_MSB:COL_LSB];

  // Address is formed from the FIFO head and captured on the pop edge itself.
  assign lin_addr      = AFW'(head_y) * AFW'(SCREEN_W) + AFW'(head_x);
  assign unused_lin_hi = lin_addr[AFW-1:ADDR_W];

`ifdef PIX_CLIP_EN
  assign clip = (32'(head_x) >= SCREEN_W) || (32'(head_y) >= SCREEN_H);
`else
  localparam int unused_screen_h = SCREEN_H;
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    load     = 1'b0;
    we_d     = fb_we;
    pix_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (clip) begin
            drop_inc = 1'b1;
          end else begin
            load    = 1'b1;
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (fb_ack) begin
          pix_inc = 1'b1;
          if (!empty) begin
            pop = 1'b1;
            // A clipped follow-on entry ends the burst; IDLE picks up the rest.
            if (clip) begin
              drop_inc = 1'b1;
              we_d     = 1'b0;
              state_d  = IDLE;
            end else begin
              load = 1'b1;
            end
          end else begin
            we_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      pix_cnt <= '0;
    end else begin
      fb_we <= we_d;
      if (load) begin
        fb_addr <= lin_addr[ADDR_W-1:0];
        fb_data <= head_col;
      end
      if (pix_inc) pix_cnt <= pix_cnt + 16'd1;
    end
  end

`ifdef PIX_CLIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        drop_cnt <= '0;
    else if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
  assign drop_cnt        = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - self-checking bench for pixel_writer
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] kbus;
  logic        kbus_valid;
  logic        kbus_ready;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ack;
  logic        busy;
  logic [15:0] pix_cnt;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_pix  = 16'd0;
  logic [15:0] exp_drop = 16'd0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  pixel_writer #(
    .FIFO_DEPTH (4),
    .SCREEN_W   (160),
    .SCREEN_H   (120),
    .ADDR_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kbus       (kbus),
    .kbus_valid (kbus_valid),
    .kbus_ready (kbus_ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ack     (fb_ack),
    .busy       (busy),
    .pix_cnt    (pix_cnt),
    .drop_cnt   (drop_cnt)
  );

  // Reference: linear address on a 160-wide screen, reduced to 16 bits.
  function automatic logic [23:0] ref_write(input logic [23:0] cmd);
    int a;
    a = (int'(cmd[15:8]) * 160 + int'(cmd[23:16])) % 65536;
    return {a[15:0], cmd[7:0]};
  endfunction

  function automatic bit ref_clipped(input logic [23:0] cmd);
`ifdef PIX_CLIP_EN
    return (int'(cmd[23:16]) >= 160) || (int'(cmd[15:8]) >= 120);
`else
    return (cmd === 24'hx);
`endif
  endfunction

  function automatic logic [23:0] rand_cmd(input bit in_range);
    logic [7:0] x, y, c;
    x = in_range ? 8'($urandom_range(0, 159)) : 8'($urandom_range(0, 255));
    y = in_range ? 8'($urandom_range(0, 119)) : 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    return {x, y, c};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; kbus = '0; kbus_valid = 1'b0; fb_ack = 1'b0;
    #12;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    checks++; if (fb_addr !== 16'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
    checks++; if (fb_data !== 8'd0) begin errors++; $display("FAIL reset_fb_data: got %0h want 0", fb_data); end
    checks++; if (pix_cnt !== 16'd0) begin errors++; $display("FAIL reset_pix_cnt: got %0d want 0", pix_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (kbus_ready !== 1'b1) begin errors++; $display("FAIL reset_kbus_ready: got %b want 1", kbus_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk); kbus = 24'h0A0533; kbus_valid = 1'b1; fb_ack = 1'b0;
    @(negedge clk); kbus_valid = 1'b0;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_early: got %b want 0", fb_we); end
    @(negedge clk);
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", fb_we); end
    checks++; if (fb_addr !== 16'd810) begin errors++; $display("FAIL single_addr: got %0d want 810", fb_addr); end
    checks++; if (fb_data !== 8'h33) begin errors++; $display("FAIL single_data: got %0h want 33", fb_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    fb_ack = 1'b1;
    @(negedge clk); fb_ack = 1'b0;
    exp_pix++;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_done: got %b want 0", fb_we); end
    checks++; if (pix_cnt !== exp_pix) begin errors++; $display("FAIL single_pix_cnt: got %0d want %0d", pix_cnt, exp_pix); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] cmds[4];
    int nwe = 0, first = -1, last = -1;
    for (int i = 0; i < 4; i++) cmds[i] = rand_cmd(1'b1);
    fb_ack = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (fb_we) begin
        checks++;
        if (nwe < 4 && {fb_addr, fb_data} !== ref_write(cmds[nwe])) begin
          errors++; $display("FAIL b2b_write%0d: got %h want %h", nwe, {fb_addr, fb_data}, ref_write(cmds[nwe]));
        end
        if (first < 0) first = cyc;
        last = cyc;
        nwe++;
      end
      if (cyc < 4) begin kbus = cmds[cyc]; kbus_valid = 1'b1; end
      else kbus_valid = 1'b0;
    end
    fb_ack = 1'b0;
    exp_pix += 16'd4;
    checks++; if (nwe != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", nwe); end
    checks++; if (last - first != 3) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 3", last - first); end
    checks++; if (pix_cnt !== exp_pix) begin errors++; $display("FAIL b2b_pix_cnt: got %0d want %0d", pix_cnt, exp_pix); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_full;
    logic [23:0] cmds[6];
    int sent = 0, w = 0;
    for (int i = 0; i < 6; i++) cmds[i] = rand_cmd(1'b1);
    fb_ack = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (sent < 6) begin
        kbus = cmds[sent]; kbus_valid = 1'b1;
        if (kbus_ready) sent++;
      end else kbus_valid = 1'b0;
    end
    checks++; if (sent != 5) begin errors++; $display("FAIL full_accepted: got %0d want 5", sent); end
    checks++; if (kbus_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", kbus_ready); end
    checks++; if ({fb_we, fb_addr, fb_data} !== {1'b1, ref_write(cmds[0])}) begin
      errors++; $display("FAIL full_hold: got %h want %h", {fb_we, fb_addr, fb_data}, {1'b1, ref_write(cmds[0])});
    end
    fb_ack = 1'b1;
    for (int cyc = 0; cyc < 30 && w < 6; cyc++) begin
      if (fb_we) begin
        checks++;
        if ({fb_addr, fb_data} !== ref_write(cmds[w])) begin
          errors++; $display("FAIL full_write%0d: got %h want %h", w, {fb_addr, fb_data}, ref_write(cmds[w]));
        end
        w++;
      end
      if (sent < 6) begin
        kbus = cmds[sent]; kbus_valid = 1'b1;
        if (kbus_ready) sent++;
      end else kbus_valid = 1'b0;
      @(negedge clk);
    end
    fb_ack = 1'b0; kbus_valid = 1'b0;
    exp_pix += 16'd6;
    checks++; if (w != 6) begin errors++; $display("FAIL full_written: got %0d want 6", w); end
    checks++; if (pix_cnt !== exp_pix) begin errors++; $display("FAIL full_pix_cnt: got %0d want %0d", pix_cnt, exp_pix); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b want 0", busy); end
  endtask

  task automatic test_clip;
    logic [23:0] cmds[2];
    logic [23:0] seen[4];
    int nwe = 0;
    cmds[0] = {8'd200, 8'd5, 8'h11};
    cmds[1] = {8'd1, 8'd1, 8'h22};
    fb_ack = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (fb_we) begin
        if (nwe < 4) seen[nwe] = {fb_addr, fb_data};
        nwe++;
      end
      if (cyc < 2) begin kbus = cmds[cyc]; kbus_valid = 1'b1; end
      else kbus_valid = 1'b0;
    end
    fb_ack = 1'b0;
`ifdef PIX_CLIP_EN
    exp_pix += 16'd1; exp_drop += 16'd1;
    checks++; if (nwe != 1) begin errors++; $display("FAIL clip_writes: got %0d want 1", nwe); end
    checks++; if (seen[0] !== {16'd161, 8'h22}) begin errors++; $display("FAIL clip_addr: got %h want %h", seen[0], {16'd161, 8'h22}); end
`else
    exp_pix += 16'd2;
    checks++; if (nwe != 2) begin errors++; $display("FAIL clip_writes: got %0d want 2", nwe); end
    checks++; if (seen[0] !== {16'd1000, 8'h11}) begin errors++; $display("FAIL clip_addr0: got %h want %h", seen[0], {16'd1000, 8'h11}); end
    checks++; if (seen[1] !== {16'd161, 8'h22}) begin errors++; $display("FAIL clip_addr1: got %h want %h", seen[1], {16'd161, 8'h22}); end
`endif
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL clip_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    checks++; if (pix_cnt !== exp_pix) begin errors++; $display("FAIL clip_pix_cnt: got %0d want %0d", pix_cnt, exp_pix); end
  endtask

  // Random stream scored against the reference queue of expected writes.
  task automatic drive_stream(input int n, input int ack_pct, input int valid_pct, input bit in_range);
    int sent = 0, cyc = 0, limit;
    bit have = 1'b0;
    limit = n * 8 + 500;
    while ((sent < n || exp_q.size() != 0 || busy) && cyc < limit) begin
      @(negedge clk); cyc++;
      checks++;
      if (pix_cnt !== exp_pix) begin
        errors++; if (errors < 20) $display("FAIL stream_pix_cnt: got %0d want %0d", pix_cnt, exp_pix);
      end
`ifndef PIX_CLIP_EN
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        errors++; if (errors < 20) $display("FAIL stream_busy: got %b want %b", busy, exp_q.size() != 0);
      end
`endif
      fb_ack = ($urandom_range(0, 99) < ack_pct);
      if (fb_we && fb_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; if (errors < 20) $display("FAIL stream_spurious_write: got %h want none", {fb_addr, fb_data});
        end else begin
          if ({fb_addr, fb_data} !== exp_q[0]) begin
            errors++; if (errors < 20) $display("FAIL stream_write: got %h want %h", {fb_addr, fb_data}, exp_q[0]);
          end
          void'(exp_q.pop_front());
          exp_pix++;
        end
      end
      if (!have && sent < n && $urandom_range(0, 99) < valid_pct) begin
        kbus = rand_cmd(in_range); have = 1'b1;
      end
      kbus_valid = have;
      if (have && kbus_ready) begin
        have = 1'b0; sent++;
        if (ref_clipped(kbus)) exp_drop++;
        else exp_q.push_back(ref_write(kbus));
      end
    end
    kbus_valid = 1'b0; fb_ack = 1'b0;
    checks++; if (cyc >= limit) begin errors++; $display("FAIL stream_timeout: got %0d cycles want < %0d", cyc, limit); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL stream_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_random;
    drive_stream(200, 60, 70, 1'b0);
    drive_stream(120, 30, 100, 1'b1);
    drive_stream(120, 100, 50, 1'b0);
  endtask

  task automatic test_wrap;
    drive_stream(int'(16'hFFFF - exp_pix), 100, 100, 1'b1);
    checks++; if (pix_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h want ffff", pix_cnt); end
    drive_stream(1, 100, 100, 1'b1);
    checks++; if (pix_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", pix_cnt); end
  endtask

  task automatic test_reset_mid_write;
    fb_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); kbus = rand_cmd(1'b1); kbus_valid = 1'b1;
    end
    @(negedge clk); kbus_valid = 1'b0;
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL rst_mid_setup_we: got %b want 1", fb_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_mid_fb_we: got %b want 0", fb_we); end
    checks++; if (kbus_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", kbus_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (pix_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_pix_cnt: got %0d want 0", pix_cnt); end
    exp_q.delete(); exp_pix = 16'd0; exp_drop = 16'd0;
    @(negedge clk); rst_n = 1'b1; fb_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({fb_we, busy, pix_cnt} !== 18'd0) begin
        errors++; $display("FAIL rst_mid_after%0d: got we=%b busy=%b pix=%0d want 0", i, fb_we, busy, pix_cnt);
      end
    end
    fb_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_clip();
    test_random();
    test_wrap();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
